// File: rtl/lfsr_random_gen.sv
// Galois LFSR random-word source: draws OUT_W fresh LFSR bits per request and
// presents them as a registered word with a one-cycle valid pulse.
module lfsr_random_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
    parameter int               OUT_W    = 2,
    parameter bit               FREE_RUN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic             stop,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] random,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] sh_q, sh_d;
    logic [OUT_W-1:0] random_q, random_d;

    logic             step_bit;
    logic [WIDTH-1:0] lfsr_stepped;
    logic [OUT_W-1:0] sh_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            sh_q     <= '0;
            random_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            random_q <= random_d;
        end
    end

    // Shifting left keeps the first drawn bit at the MSB; also correct for OUT_W == 1.
    always_comb begin
        step_bit     = lfsr_q[0];
        lfsr_stepped = (lfsr_q >> 1) ^ (step_bit ? TAPS : '0);
        sh_shifted   = (sh_q << 1) | OUT_W'(step_bit);
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        random_d = random_q;
        if (seed_load) begin
            // A zero seed would lock the LFSR, so the default seed is substituted.
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (!stop) begin
            case (state_q)
                ST_IDLE: begin
                    if (FREE_RUN) begin
                        lfsr_d = lfsr_stepped;
                    end
                    if (req) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    lfsr_d = lfsr_stepped;
                    sh_d   = sh_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(OUT_W - 1)) begin
                        state_d  = ST_DONE;
                        random_d = sh_shifted;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        valid      = (state_q == ST_DONE);
        random     = random_q;
        lfsr_state = lfsr_q;
    end

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Bench for lfsr_random_gen: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based draw model.
module tb_lfsr_random_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_seed_load = 1'b0, a_req = 1'b0, a_stop = 1'b0;
    logic [15:0] a_seed_in = '0;
    logic        a_busy, a_valid;
    logic [1:0]  a_random;
    logic [15:0] a_state;

    // Instance B: 4-bit free-running LFSR for the period test
    logic        b_seed_load = 1'b0, b_req = 1'b0, b_stop = 1'b0;
    logic [3:0]  b_seed_in = '0;
    logic        b_busy, b_valid;
    logic [1:0]  b_random;
    logic [3:0]  b_state;

    // Instance C: 4-bit output words for the stall test
    logic        c_seed_load = 1'b0, c_req = 1'b0, c_stop = 1'b0;
    logic [15:0] c_seed_in = '0;
    logic        c_busy, c_valid;
    logic [3:0]  c_random;
    logic [15:0] c_state;

    lfsr_random_gen dut_a (
        .clk(clk), .rst(rst), .seed_load(a_seed_load), .seed_in(a_seed_in),
        .req(a_req), .stop(a_stop), .busy(a_busy), .valid(a_valid),
        .random(a_random), .lfsr_state(a_state)
    );

    lfsr_random_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(2), .FREE_RUN(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .seed_load(b_seed_load), .seed_in(b_seed_in),
        .req(b_req), .stop(b_stop), .busy(b_busy), .valid(b_valid),
        .random(b_random), .lfsr_state(b_state)
    );

    lfsr_random_gen #(.OUT_W(4)) dut_c (
        .clk(clk), .rst(rst), .seed_load(c_seed_load), .seed_in(c_seed_in),
        .req(c_req), .stop(c_stop), .busy(c_busy), .valid(c_valid),
        .random(c_random), .lfsr_state(c_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One Galois step as arithmetic: halve, then fold the taps in if the dropped bit was 1.
    function automatic int unsigned galois(input int unsigned s, input int unsigned taps);
        return (s / 2) ^ ((s % 2) * taps);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of instance A: phase 0 idle, 1 collecting bits, 2 word presented.
    int unsigned m_lfsr   = 32'hACE1;
    int          m_phase  = 0;
    int unsigned m_random = 0;
    bit          m_bits[$];

    task automatic a_cycle(input logic sl, input logic [15:0] si, input logic rq, input logic st);
        a_seed_load = sl; a_seed_in = si; a_req = rq; a_stop = st;
        @(posedge clk);
        if (sl) begin
            m_lfsr  = (si == 16'h0) ? 32'hACE1 : int'(si);
            m_phase = 0;
            m_bits.delete();
        end else if (!st) begin
            case (m_phase)
                0: if (rq) begin m_phase = 1; m_bits.delete(); end
                1: begin
                    m_bits.push_back(bit'(m_lfsr % 2));
                    m_lfsr = galois(m_lfsr, 32'hB400);
                    if (m_bits.size() == 2) begin
                        m_random = 0;
                        foreach (m_bits[i]) m_random = m_random * 2 + int'(m_bits[i]);
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        check("model_busy",  32'(a_busy),   32'(m_phase != 0));
        check("model_valid", 32'(a_valid),  32'(m_phase == 2));
        check("model_random",32'(a_random), m_random);
        check("model_state", 32'(a_state),  m_lfsr);
        if (a_valid) $display("draw: random=%0d lfsr=0x%04h", a_random, a_state);
    endtask

    typedef struct {
        logic        sl;
        logic [15:0] si;
        logic        rq;
        logic        st;
        logic        ebusy;
        logic        evalid;
        logic [1:0]  erand;
        logic [15:0] estate;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int unsigned s;
        bit          stream[16];
        bit          visited[16];
        int          words, last_i, lat;
        logic [15:0] frz;
        logic [3:0]  r1, exp4;

        tbl[0] = '{1'b0, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'hACE1};
        tbl[1] = '{1'b0, 16'h0000,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'hE270};
        tbl[2] = '{1'b0, 16'h0000,  1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'h7138};
        tbl[3] = '{1'b0, 16'h0000,  1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 16'h7138};
        tbl[4] = '{1'b0, 16'h0000,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'h7138};
        tbl[5] = '{1'b1, 16'h0000,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'hACE1};
        tbl[6] = '{1'b1, 16'h1234,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'h1234};
        tbl[7] = '{1'b0, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 16'h1234};
        tbl[8] = '{1'b1, 16'hACE1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 16'hACE1};
        tbl[9] = '{1'b0, 16'h0000,  1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 16'hACE1};

        rst = 1'b1;
        tick();
        tick();
        check("rst_busy",   32'(a_busy),   0);
        check("rst_valid",  32'(a_valid),  0);
        check("rst_random", 32'(a_random), 0);
        check("rst_state",  32'(a_state),  32'hACE1);
        check("rst_b_state",32'(b_state),  1);
        check("rst_c_state",32'(c_state),  32'hACE1);
        rst = 1'b0;

        // Period of the 4-bit LFSR: 15 distinct nonzero states, back to the seed.
        s = 1;
        for (int i = 0; i < 16; i++) visited[i] = 1'b0;
        for (int step = 1; step <= 15; step++) begin
            tick();
            check("period_step",     32'(b_state), galois(s, 32'hC));
            check("period_nonzero",  32'(b_state != 4'h0), 1);
            check("period_unique",   32'(visited[b_state]), 0);
            visited[b_state] = 1'b1;
            s = 32'(b_state);
        end
        check("period_return", 32'(b_state), 1);

        // Directed vector table on instance A.
        for (int i = 0; i < 10; i++) begin
            a_cycle(tbl[i].sl, tbl[i].si, tbl[i].rq, tbl[i].st);
            check($sformatf("vec%0d_busy", i),   32'(a_busy),   32'(tbl[i].ebusy));
            check($sformatf("vec%0d_valid", i),  32'(a_valid),  32'(tbl[i].evalid));
            check($sformatf("vec%0d_random", i), 32'(a_random), 32'(tbl[i].erand));
            check($sformatf("vec%0d_state", i),  32'(a_state),  32'(tbl[i].estate));
        end

        // Back-to-back draws from the default seed with req held high.
        a_cycle(1'b1, 16'h0000, 1'b0, 1'b0);
        s = 32'hACE1;
        for (int i = 0; i < 16; i++) begin
            stream[i] = bit'(s % 2);
            s = galois(s, 32'hB400);
        end
        words = 0;
        last_i = 0;
        for (int i = 0; i < 12; i++) begin
            a_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
            if (a_valid) begin
                check("b2b_word", 32'(a_random),
                      32'({stream[2*words], stream[2*words+1]}));
                if (words > 0) check("b2b_spacing", 32'(i - last_i), 4);
                last_i = i;
                words++;
            end
        end
        check("b2b_count", 32'(words), 3);
        for (int i = 0; i < 3; i++) a_cycle(1'b0, 16'h0000, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            a_cycle(($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 4) == 0));
        end

        // Stall mid-draw on instance C: same word, valid delayed by the stop length.
        exp4 = {stream[0], stream[1], stream[2], stream[3]};
        c_seed_load = 1'b1; c_seed_in = 16'h0000;
        tick();
        c_seed_load = 1'b0;
        c_req = 1'b1;
        tick();
        c_req = 1'b0;
        lat = 0;
        while (!c_valid && lat < 20) begin tick(); lat++; end
        check("stall_ref_latency", 32'(lat), 4);
        check("stall_ref_word", 32'(c_random), 32'(exp4));
        $display("draw: c random=0x%0h latency=%0d", c_random, lat);
        r1 = c_random;
        tick();
        c_seed_load = 1'b1; c_seed_in = 16'h0000;
        tick();
        c_seed_load = 1'b0;
        check("stall_reseed", 32'(c_state), 32'hACE1);
        c_req = 1'b1;
        tick();
        c_req = 1'b0;
        tick();
        tick();
        frz = c_state;
        c_stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_state", 32'(c_state), 32'(frz));
            check("stall_busy",  32'(c_busy),  1);
            check("stall_valid", 32'(c_valid), 0);
        end
        c_stop = 1'b0;
        lat = 0;
        while (!c_valid && lat < 20) begin tick(); lat++; end
        check("stall_tail_latency", 32'(lat), 2);
        check("stall_word", 32'(c_random), 32'(r1));
        $display("draw: c stalled random=0x%0h", c_random);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_random_gen.md
Name: lfsr_random_gen

Overview:
- Parametrised Galois LFSR random-number source for the VGA/game logic.
- Produces an OUT_W-bit random word on request through a req/valid handshake, one fresh LFSR bit per cycle.
- Supports runtime seed loading, global freeze (stop), an optional free-running mode, and zero-state lockup protection.
- Replaces fixed-width, clock-gated random generators; uses one clock and no gated clocks.

Parameters:
- WIDTH, 16: LFSR state width in bits (3..32).
- TAPS, 16'hB400: Galois feedback mask, WIDTH bits, maximal-length polynomial; TAPS[WIDTH-1] must be 1.
- SEED, 16'hACE1: reset and substitute seed, WIDTH bits, nonzero.
- OUT_W, 2: random word width (1..WIDTH).
- FREE_RUN, 0: 1 = LFSR also steps every non-frozen IDLE cycle.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  WIDTH  seed value; 0 is replaced by SEED.
- req  in  1  request a new random word; sampled only in IDLE.
- stop  in  1  freeze: state, counter, FSM and outputs all hold.
- busy  out  1  high while FSM is not IDLE.
- valid  out  1  high while FSM is in DONE; random is valid.
- random  out  OUT_W  last completed random word.
- lfsr_state  out  WIDTH  current LFSR state (debug).

Behaviour:
- Priority per edge: rst > seed_load > stop > normal operation.
- Reset values:
  - lfsr = SEED, FSM = IDLE, bit counter = 0, shift register = 0.
  - random = 0, valid = 0, busy = 0.
- LFSR step (Galois, right shift): b = lfsr[0]; lfsr <= (lfsr >> 1) ^ (b ? TAPS : 0). The output bit of a step is b.
- Draw shift register: sh <= {sh[OUT_W-2:0], b}. For OUT_W = 1, sh <= b. The first bit produced ends up as the MSB.
- FSM states:
  - IDLE:
    - req=1 and stop=0 → SHIFT; counter cleared to 0.
    - If FREE_RUN=1, lfsr steps each non-frozen IDLE cycle; these bits are not captured.
  - SHIFT:
    - Each non-frozen cycle: one step, shift b into sh, counter+1.
    - On the step where counter reaches OUT_W-1 → DONE; random <= final sh value, on the same edge.
  - DONE:
    - valid=1 for this cycle; next non-frozen edge → IDLE.
    - lfsr does not step in DONE.
- Latency: with req accepted at edge k, random is updated and valid rises at edge k+OUT_W, provided no stop cycles occur. valid is high for exactly one clock.
- req while busy: ignored, not queued. req held high through DONE: re-accepted on the first IDLE cycle, so back-to-back draws occur every OUT_W+2 cycles.
- random holds its value until the next completed draw; it is not cleared in IDLE.
- stop=1: no register changes. valid and busy hold their current values; if frozen in DONE, valid stays high and consumers must qualify valid with !stop.
- seed_load=1:
  - lfsr <= (seed_in==0) ? SEED : seed_in.
  - FSM → IDLE, counter → 0; any in-flight draw is aborted with no valid.
  - random is unchanged; a simultaneous req is dropped.
- Lockup: the LFSR state must never be 0. This holds by construction through reset and the seed substitution; no other path writes lfsr.
- busy = (FSM != IDLE), registered-state decode; no combinational path from req to busy or valid.

Test Plan:
- Reset then draw: rst for 2 cycles, then req=1 for one cycle (defaults, FREE_RUN=0) → lfsr 0xACE1→0xE270→0x7138; valid pulses 2 cycles after req edge; random=2'b10; busy high for 3 cycles.
- Period: WIDTH=4, TAPS=4'hC, SEED=4'h1, FREE_RUN=1, no req → lfsr_state returns to 4'h1 after exactly 15 steps; all 15 nonzero states visited once; never 0.
- Zero seed: seed_load=1, seed_in=0 → lfsr_state=SEED next cycle. seed_load=1, seed_in=16'h1234 → lfsr_state=16'h1234.
- Stop mid-draw: OUT_W=4; req, then stop=1 for 5 cycles after the second SHIFT step → lfsr_state, busy and counter frozen; valid arrives 5 cycles later than nominal; random is identical to the unstalled run.
- Abort: seed_load asserted during SHIFT → FSM IDLE next cycle, no valid, random keeps its previous value; req in the same cycle as seed_load is ignored.
- Back-to-back: req held high for 12 cycles, OUT_W=2 → valid pulses every 4 cycles. Successive random words equal consecutive bit pairs of a software Galois model run from SEED.
